// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: core has fixed priority, debug is protected from
// starvation by a burst counter. Stores complete in the grant cycle; loads return one cycle later.
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic {IDLE, RESP} state_t;
    typedef enum logic {OWN_CORE, OWN_DBG} owner_t;

    state_t           state, state_nxt;
    owner_t           owner, owner_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
    logic             dbg_wins;

    // State, owner and burst counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= OWN_CORE;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Arbitration, memory drive and response steering
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        dbg_wins      = 1'b0;
        core_gnt      = 1'b0;
        dbg_gnt       = 1'b0;
        core_rvalid   = 1'b0;
        dbg_rvalid    = 1'b0;
        core_rdata    = '0;
        dbg_rdata     = '0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;

        case (state)
            IDLE: begin
                // Grants are gated by reset so outputs drop to zero asynchronously
                if (reset) begin
                    dbg_wins = dbg_req && (!core_req || burst_cnt == BURST_MAX);
                    if (dbg_wins) begin
                        dbg_gnt       = 1'b1;
                        mem_en        = 1'b1;
                        mem_we        = dbg_we;
                        mem_addr      = dbg_addr;
                        mem_wdata     = dbg_wdata;
                        burst_cnt_nxt = '0;
                        if (!dbg_we) begin
                            state_nxt = RESP;
                            owner_nxt = OWN_DBG;
                        end
                    end else if (core_req) begin
                        core_gnt  = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = core_we;
                        mem_addr  = core_addr;
                        mem_wdata = core_wdata;
                        if (dbg_req && burst_cnt != BURST_MAX) begin
                            burst_cnt_nxt = burst_cnt + CNT_W'(1);
                        end
                        if (!core_we) begin
                            state_nxt = RESP;
                            owner_nxt = OWN_CORE;
                        end
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
                if (owner == OWN_DBG) begin
                    dbg_rvalid = 1'b1;
                    dbg_rdata  = mem_rdata;
                end else begin
                    core_rvalid = 1'b1;
                    core_rdata  = mem_rdata;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!dbg_req) begin
            burst_cnt_nxt = '0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for starvation, reset-in-response and debug withdrawal.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        core_req, core_we, dbg_req, dbg_we;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata, mem_rdata;
    logic        core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] core_rdata, dbg_rdata, mem_addr, mem_wdata;
    logic        mem_en, mem_we, busy;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        creq, cwe;
        logic [31:0] caddr, cwdata;
        logic        dreq, dwe;
        logic [31:0] daddr, dwdata, mrdata;
        logic        cgnt, dgnt, crv;
        logic [31:0] crd;
        logic        drv;
        logic [31:0] drd;
        logic        men, mwe;
        logic [31:0] maddr, mwd;
        logic        bsy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic dreq, input logic dwe,
                         input logic [31:0] daddr, input logic [31:0] dwd);
        core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
        dbg_req  = dreq; dbg_we  = dwe; dbg_addr  = daddr; dbg_wdata  = dwd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " core_gnt"}, 32'(core_gnt), 0);
        chk({tag, " dbg_gnt"}, 32'(dbg_gnt), 0);
        chk({tag, " core_rvalid"}, 32'(core_rvalid), 0);
        chk({tag, " dbg_rvalid"}, 32'(dbg_rvalid), 0);
        chk({tag, " core_rdata"}, core_rdata, 0);
        chk({tag, " dbg_rdata"}, dbg_rdata, 0);
        chk({tag, " mem_en"}, 32'(mem_en), 0);
        chk({tag, " mem_we"}, 32'(mem_we), 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " busy"}, 32'(busy), 0);
    endtask

    vec_t  vecs[13];
    string pat;
    logic  exp_dbg;

    initial begin
        // creq cwe caddr cwdata | dreq dwe daddr dwdata | mrdata || cgnt dgnt crv crd drv drd | men mwe maddr mwd | busy
        vecs[0]  = '{0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,    32'h0,        0,0,0,32'h0,        0,32'h0,        0,0,32'h0, 32'h0,        0};
        vecs[1]  = '{1,1,32'h10,32'hDEADBEEF, 0,0,32'h0, 32'h0,    32'h0,        1,0,0,32'h0,        0,32'h0,        1,1,32'h10,32'hDEADBEEF, 0};
        vecs[2]  = '{1,1,32'h14,32'h1,        0,0,32'h0, 32'h0,    32'h0,        1,0,0,32'h0,        0,32'h0,        1,1,32'h14,32'h1,        0};
        vecs[3]  = '{1,0,32'h20,32'h0,        0,0,32'h0, 32'h0,    32'h0,        1,0,0,32'h0,        0,32'h0,        1,0,32'h20,32'h0,        0};
        vecs[4]  = '{1,1,32'h24,32'h77,       0,0,32'h0, 32'h0,    32'h12345678, 0,0,1,32'h12345678, 0,32'h0,        0,0,32'h0, 32'h0,        1};
        vecs[5]  = '{0,0,32'h0, 32'h0,        1,1,32'h40,32'hCAFE, 32'h12345678, 0,1,0,32'h0,        0,32'h0,        1,1,32'h40,32'hCAFE,     0};
        vecs[6]  = '{0,0,32'h0, 32'h0,        1,0,32'h44,32'h0,    32'h0,        0,1,0,32'h0,        0,32'h0,        1,0,32'h44,32'h0,        0};
        vecs[7]  = '{1,0,32'h30,32'h0,        0,0,32'h0, 32'h0,    32'hA5A5A5A5, 0,0,0,32'h0,        1,32'hA5A5A5A5, 0,0,32'h0, 32'h0,        1};
        vecs[8]  = '{1,0,32'h50,32'h0,        1,0,32'h60,32'h0,    32'h0,        1,0,0,32'h0,        0,32'h0,        1,0,32'h50,32'h0,        0};
        vecs[9]  = '{0,0,32'h0, 32'h0,        1,0,32'h60,32'h0,    32'h11112222, 0,0,1,32'h11112222, 0,32'h0,        0,0,32'h0, 32'h0,        1};
        vecs[10] = '{0,0,32'h0, 32'h0,        1,0,32'h60,32'h0,    32'h0,        0,1,0,32'h0,        0,32'h0,        1,0,32'h60,32'h0,        0};
        vecs[11] = '{0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,    32'h33334444, 0,0,0,32'h0,        1,32'h33334444, 0,0,32'h0, 32'h0,        1};
        vecs[12] = '{0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,    32'h0,        0,0,0,32'h0,        0,32'h0,        0,0,32'h0, 32'h0,        0};

        // Reset held with requests raised: outputs must stay zero
        reset = 1'b0;
        mem_rdata = 32'h0;
        drive(1, 1, 32'h10, 32'h55, 1, 1, 32'h20, 32'h66);
        #12;
        chk_all_zero("reset");
        chk("reset burst_cnt", 32'(dut.burst_cnt), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwdata,
                  vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwdata);
            mem_rdata = vecs[i].mrdata;
            #1;
            chk($sformatf("v%0d core_gnt", i), 32'(core_gnt), 32'(vecs[i].cgnt));
            chk($sformatf("v%0d dbg_gnt", i), 32'(dbg_gnt), 32'(vecs[i].dgnt));
            chk($sformatf("v%0d core_rvalid", i), 32'(core_rvalid), 32'(vecs[i].crv));
            chk($sformatf("v%0d core_rdata", i), core_rdata, vecs[i].crd);
            chk($sformatf("v%0d dbg_rvalid", i), 32'(dbg_rvalid), 32'(vecs[i].drv));
            chk($sformatf("v%0d dbg_rdata", i), dbg_rdata, vecs[i].drd);
            chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(vecs[i].men));
            chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].mwe));
            chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].maddr);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].mwd);
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
        end
        mem_rdata = 32'h0;

        // Starvation guard: both stores held, expected C,C,C,C,D,C,C,C,C,D
        pat = "CCCCDCCCCD";
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1, 1, 32'h100, 32'(i), 1, 1, 32'h200, 32'(i + 100));
            #1;
            exp_dbg = (pat[i] == "D");
            chk($sformatf("starve%0d core_gnt", i), 32'(core_gnt), 32'(!exp_dbg));
            chk($sformatf("starve%0d dbg_gnt", i), 32'(dbg_gnt), 32'(exp_dbg));
            chk($sformatf("starve%0d mem_addr", i), mem_addr, exp_dbg ? 32'h200 : 32'h100);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Debug raised then withdrawn while core keeps priority
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 1, 32'h300, 32'h1, i < 2, 1, 32'h400, 32'h2);
            #1;
            chk($sformatf("withdraw%0d dbg_gnt", i), 32'(dbg_gnt), 0);
            chk($sformatf("withdraw%0d core_gnt", i), 32'(core_gnt), 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("withdraw burst_cnt", 32'(dut.burst_cnt), 0);

        // Reset pulse in the response cycle of a debug load
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 32'h500, 32'h0);
        #1;
        chk("rstresp dbg_gnt", 32'(dbg_gnt), 1);
        @(negedge clk);
        drive(1, 0, 32'h600, 0, 0, 0, 0, 0);
        mem_rdata = 32'hBEEFCAFE;
        #1;
        chk("rstresp dbg_rvalid pre", 32'(dbg_rvalid), 1);
        reset = 1'b0;
        #1;
        chk_all_zero("rstresp");
        chk("rstresp burst_cnt", 32'(dut.burst_cnt), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("postrst%0d dbg_rvalid", i), 32'(dbg_rvalid), 0);
            chk($sformatf("postrst%0d busy", i), 32'(busy), 0);
            @(negedge clk);
        end

        // First grant right after reset release
        reset = 1'b0;
        #2;
        reset = 1'b1;
        drive(1, 1, 32'h700, 32'h9, 0, 0, 0, 0);
        #1;
        chk("firstgnt core_gnt", 32'(core_gnt), 1);
        chk("firstgnt mem_addr", mem_addr, 32'h700);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("idle busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_BURST, 4, maximum consecutive core grants while debug waits; legal range 1-15.

REQ-002 Ports SHALL be as follows, one per line:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core load/store request.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  ADDR_W  core word address.
- core_wdata  in  DATA_W  core store data.
- core_gnt  out  1  core request accepted this cycle.
- core_rvalid  out  1  core load data valid.
- core_rdata  out  DATA_W  core load data.
- dbg_req  in  1  debug/loader request.
- dbg_we  in  1  1 = store, 0 = load.
- dbg_addr  in  ADDR_W  debug word address.
- dbg_wdata  in  DATA_W  debug store data.
- dbg_gnt  out  1  debug request accepted this cycle.
- dbg_rvalid  out  1  debug load data valid.
- dbg_rdata  out  DATA_W  debug load data.
- mem_en  out  1  data-memory access strobe.
- mem_we  out  1  data-memory write enable.
- mem_addr  out  ADDR_W  data-memory address.
- mem_wdata  out  DATA_W  data-memory write data.
- mem_rdata  in  DATA_W  data-memory read data, valid 1 cycle after mem_en with mem_we = 0.
- busy  out  1  high whenever state is not IDLE.

REQ-003 The clock SHALL be clk, and reset SHALL be asynchronous and active-low on port reset.

Function
REQ-004 The FSM SHALL have two states, IDLE and RESP.
REQ-005 In IDLE with at least one req high, exactly one requester SHALL be granted in that same cycle: its gnt = 1, mem_en = 1, and mem_we/mem_addr/mem_wdata driven combinationally from the winner's inputs.
REQ-006 Arbitration SHALL be fixed priority, core over debug, except when burst_cnt == MAX_BURST and dbg_req = 1; debug SHALL then win.
REQ-007 burst_cnt (4-bit) SHALL increment on each core grant made while dbg_req = 1, saturating at MAX_BURST.
REQ-008 burst_cnt SHALL clear on any debug grant and on any cycle with dbg_req = 0.
REQ-009 A granted store SHALL complete in the grant cycle, and the FSM SHALL remain in IDLE, allowing back-to-back stores at 1 per cycle.
REQ-010 A granted load SHALL move the FSM to RESP and register the owner.
REQ-011 In RESP, the owner's rvalid SHALL be 1 for exactly one cycle, with rdata = mem_rdata; the FSM SHALL return to IDLE on the next edge.
REQ-012 No grant SHALL be issued in RESP; load throughput is therefore 1 per 2 cycles.
REQ-013 rdata outputs SHALL be 0 whenever the corresponding rvalid = 0, and rvalid SHALL never be asserted to the non-owner.
REQ-014 When mem_en = 0, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-015 Handshake: a requester SHALL hold req/we/addr/wdata stable until gnt; the arbiter SHALL accept req deassertion before gnt without side effects.
REQ-016 A req lowered or changed during RESP SHALL not affect the pending response.
REQ-017 Simultaneous requests SHALL produce exactly one gnt per cycle, and gnt SHALL never be 1 when the matching req = 0.

Reset
REQ-018 While reset = 0, state SHALL be IDLE, burst_cnt SHALL be 0, the owner register SHALL be cleared, and all outputs SHALL be 0, asynchronously.
REQ-019 Reset asserted during RESP SHALL abort the response, with no rvalid after release.
REQ-020 The first grant SHALL be possible in the first clk edge cycle after reset = 1.

Verification
REQ-021 Core store: core_req = 1, core_we = 1, addr 0x10, wdata 0xDEADBEEF -> same cycle core_gnt = 1, mem_en = 1, mem_we = 1, mem_addr = 0x10; busy stays 0.
REQ-022 Core load: mem returns 0x12345678 -> core_gnt in cycle N, core_rvalid = 1 with core_rdata = 0x12345678 in cycle N+1, and no grant in N+1.
REQ-023 Starvation guard: core and debug stores both held high with MAX_BURST = 4 -> grant sequence C,C,C,C,D,C,C,C,C,D.
REQ-024 Simultaneous loads -> core served first (rvalid at N+1), debug granted at N+2 with dbg_rvalid at N+3; dbg_rvalid never accompanies core data.
REQ-025 Reset pulse in the RESP cycle of a debug load -> dbg_rvalid = 0 throughout and after release, busy = 0, burst_cnt = 0.
REQ-026 Debug req raised then dropped while the core holds priority -> dbg_gnt never asserted and burst_cnt returns to 0.
